// File: rtl/write_cmd_route.sv
// rtl/write_cmd_route.sv - registered write-command router with linefill merge on the south lanes
//
// Each lane L = d*HASH_NUM+h owns one output register. The register feeds RAM_PER_HASH outputs
// O = L*RAM_PER_HASH+sel. Only the selected valid is raised. The payload is broadcast to every
// output of the lane. On the SOUTH_DIR lanes, linefill and south commands share the register
// through a linefill-priority arbiter with a starvation guard.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   cmd_vld/pld/rdy   per-lane command handshake (DIR_NUM*HASH_NUM lanes)
//   lf_vld/pld/rdy    per-hash linefill handshake, merged into the SOUTH_DIR lanes
//   ram_vld/pld/rdy   per-RAM output handshake (DIR_NUM*HASH_NUM*RAM_PER_HASH)
//   sel_err           one-cycle pulse per lane when an accepted command selected a missing RAM

package write_cmd_route_pkg;
  typedef struct packed {
    logic [3:0]  dest_ram_id;
    logic [15:0] addr;
  } req_cmd_pld_t;

  typedef struct packed {
    req_cmd_pld_t req_cmd_pld;
    logic [7:0]   wr_id;
  } write_cmd_t;

  typedef struct packed {
    write_cmd_t  write_cmd;
    logic [31:0] data;
  } write_ram_pld_t;
endpackage

module write_cmd_route
  import write_cmd_route_pkg::*;
#(
  parameter int DIR_NUM      = 4,
  parameter int HASH_NUM     = 4,
  parameter int RAM_PER_HASH = 2,
  parameter int SOUTH_DIR    = 2,
  parameter int STARVE_MAX   = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [DIR_NUM*HASH_NUM-1:0]              cmd_vld,
  input  write_ram_pld_t                           cmd_pld [DIR_NUM*HASH_NUM],
  output logic [DIR_NUM*HASH_NUM-1:0]              cmd_rdy,
  input  logic [HASH_NUM-1:0]                      lf_vld,
  input  write_ram_pld_t                           lf_pld [HASH_NUM],
  output logic [HASH_NUM-1:0]                      lf_rdy,
  output logic [DIR_NUM*HASH_NUM*RAM_PER_HASH-1:0] ram_vld,
  output write_ram_pld_t                           ram_pld [DIR_NUM*HASH_NUM*RAM_PER_HASH],
  input  logic [DIR_NUM*HASH_NUM*RAM_PER_HASH-1:0] ram_rdy,
  output logic [DIR_NUM*HASH_NUM-1:0]              sel_err
);

  localparam int LANE_NUM  = DIR_NUM * HASH_NUM;
  localparam int RAM_SEL_W = (RAM_PER_HASH > 1) ? $clog2(RAM_PER_HASH) : 1;
  localparam int CNT_W     = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  // A select can only point past the last RAM when the RAM count is not a power of two.
  localparam bit SEL_CAN_OVF = ((1 << RAM_SEL_W) != RAM_PER_HASH);

  logic [LANE_NUM-1:0]  slot_vld_q, slot_vld_d;
  write_ram_pld_t       slot_pld_q [LANE_NUM];
  write_ram_pld_t       slot_pld_d [LANE_NUM];
  logic [RAM_SEL_W-1:0] slot_sel_q [LANE_NUM];
  logic [RAM_SEL_W-1:0] slot_sel_d [LANE_NUM];
  logic [LANE_NUM-1:0]  sel_err_q, sel_err_d;
  logic [CNT_W-1:0]     starve_q [HASH_NUM];
  logic [CNT_W-1:0]     starve_d [HASH_NUM];

  logic [LANE_NUM-1:0]  fire;
  logic [LANE_NUM-1:0]  acc;
  logic [HASH_NUM-1:0]  lf_win;
  logic [LANE_NUM-1:0]  in_vld;
  write_ram_pld_t       in_pld [LANE_NUM];
  logic [RAM_SEL_W-1:0] in_sel [LANE_NUM];
  logic [LANE_NUM-1:0]  in_bad;

  // Ready on the unselected outputs of a lane is ignored.
  always_comb begin
    fire = '0;
    for (int l = 0; l < LANE_NUM; l++) begin
      for (int k = 0; k < RAM_PER_HASH; k++) begin
        if (slot_vld_q[l] && (slot_sel_q[l] == RAM_SEL_W'(k)) && ram_rdy[l*RAM_PER_HASH+k]) begin
          fire[l] = 1'b1;
        end
      end
    end
    acc = ~slot_vld_q | fire;
  end

  always_comb begin
    ram_vld = '0;
    for (int l = 0; l < LANE_NUM; l++) begin
      for (int k = 0; k < RAM_PER_HASH; k++) begin
        ram_vld[l*RAM_PER_HASH+k] = slot_vld_q[l] && (slot_sel_q[l] == RAM_SEL_W'(k));
        ram_pld[l*RAM_PER_HASH+k] = slot_pld_q[l];
      end
    end
  end

  // Linefill wins unless the waiting south command has been passed over STARVE_MAX times.
  always_comb begin
    lf_win = '0;
    for (int h = 0; h < HASH_NUM; h++) begin
      lf_win[h] = lf_vld[h] &&
                  !(cmd_vld[SOUTH_DIR*HASH_NUM+h] && (starve_q[h] == CNT_W'(STARVE_MAX)));
    end
  end

  always_comb begin
    cmd_rdy = '0;
    lf_rdy  = '0;
    in_vld  = '0;
    for (int l = 0; l < LANE_NUM; l++) begin
      if ((l / HASH_NUM) == SOUTH_DIR) begin
        in_vld[l]  = cmd_vld[l] | lf_vld[l % HASH_NUM];
        in_pld[l]  = lf_win[l % HASH_NUM] ? lf_pld[l % HASH_NUM] : cmd_pld[l];
        cmd_rdy[l] = acc[l] & ~lf_win[l % HASH_NUM];
        lf_rdy[l % HASH_NUM] = acc[l] & lf_win[l % HASH_NUM];
      end else begin
        in_vld[l]  = cmd_vld[l];
        in_pld[l]  = cmd_pld[l];
        cmd_rdy[l] = acc[l];
      end
      in_sel[l] = in_pld[l].write_cmd.req_cmd_pld.dest_ram_id[RAM_SEL_W-1:0];
    end
  end

  if (SEL_CAN_OVF) begin : g_sel_ovf
    always_comb begin
      in_bad = '0;
      for (int l = 0; l < LANE_NUM; l++) begin
        in_bad[l] = (in_sel[l] >= RAM_SEL_W'(RAM_PER_HASH));
      end
    end
  end else begin : g_sel_pow2
    assign in_bad = '0;
  end

  // A bad select is still handshaken but never reaches the slot.
  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_pld_d = slot_pld_q;
    slot_sel_d = slot_sel_q;
    sel_err_d  = '0;
    for (int l = 0; l < LANE_NUM; l++) begin
      if (acc[l]) begin
        slot_vld_d[l] = in_vld[l] & ~in_bad[l];
        if (in_vld[l] && !in_bad[l]) begin
          slot_pld_d[l] = in_pld[l];
          slot_sel_d[l] = in_sel[l];
        end
      end
      sel_err_d[l] = acc[l] & in_vld[l] & in_bad[l];
    end
  end

  // The counter only moves on a cycle that actually grants. It saturates at STARVE_MAX
  // because the south command is forced as soon as it gets there.
  always_comb begin
    starve_d = starve_q;
    for (int h = 0; h < HASH_NUM; h++) begin
      if (!cmd_vld[SOUTH_DIR*HASH_NUM+h]) begin
        starve_d[h] = '0;
      end else if (acc[SOUTH_DIR*HASH_NUM+h]) begin
        starve_d[h] = lf_win[h] ? (starve_q[h] + 1'b1) : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q <= '0;
      sel_err_q  <= '0;
      for (int l = 0; l < LANE_NUM; l++) begin
        slot_pld_q[l] <= '0;
        slot_sel_q[l] <= '0;
      end
      for (int h = 0; h < HASH_NUM; h++) begin
        starve_q[h] <= '0;
      end
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_pld_q <= slot_pld_d;
      slot_sel_q <= slot_sel_d;
      sel_err_q  <= sel_err_d;
      starve_q   <= starve_d;
    end
  end

  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_write_cmd_route.sv
// tb/tb_write_cmd_route.sv - scoreboard bench for write_cmd_route
module tb_write_cmd_route;
  import write_cmd_route_pkg::*;

  localparam int HASH_NUM = 4;
  localparam int R        = 2;
  localparam int SOUTH    = 2;
  localparam int STARVE   = 4;
  localparam int LANES    = 16;
  localparam int OUTS     = LANES * R;
  localparam int OUTS_B   = LANES * 3;

  logic clk = 1'b0;
  logic rst_n;

  logic [LANES-1:0]    cmd_vld, cmd_rdy, sel_err;
  write_ram_pld_t      cmd_pld [LANES];
  logic [HASH_NUM-1:0] lf_vld, lf_rdy;
  write_ram_pld_t      lf_pld [HASH_NUM];
  logic [OUTS-1:0]     ram_vld, ram_rdy;
  write_ram_pld_t      ram_pld [OUTS];

  logic [LANES-1:0]    b_cmd_vld, b_cmd_rdy, b_sel_err;
  write_ram_pld_t      b_cmd_pld [LANES];
  logic [HASH_NUM-1:0] b_lf_vld, b_lf_rdy;
  write_ram_pld_t      b_lf_pld [HASH_NUM];
  logic [OUTS_B-1:0]   b_ram_vld, b_ram_rdy;
  write_ram_pld_t      b_ram_pld [OUTS_B];

  write_cmd_route dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_pld(cmd_pld), .cmd_rdy(cmd_rdy),
    .lf_vld(lf_vld), .lf_pld(lf_pld), .lf_rdy(lf_rdy),
    .ram_vld(ram_vld), .ram_pld(ram_pld), .ram_rdy(ram_rdy),
    .sel_err(sel_err)
  );

  write_cmd_route #(.RAM_PER_HASH(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(b_cmd_vld), .cmd_pld(b_cmd_pld), .cmd_rdy(b_cmd_rdy),
    .lf_vld(b_lf_vld), .lf_pld(b_lf_pld), .lf_rdy(b_lf_rdy),
    .ram_vld(b_ram_vld), .ram_pld(b_ram_pld), .ram_rdy(b_ram_rdy),
    .sel_err(b_sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    write_ram_pld_t pld;
    int             sel;
  } exp_t;

  exp_t exp_q [LANES][$];
  int   acc_cnt [LANES];
  int   fire_cnt [LANES];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check_eq(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic write_ram_pld_t mk(input int tag, input int seq, input int dest);
    write_ram_pld_t p;
    p.write_cmd.req_cmd_pld.dest_ram_id = 4'(dest);
    p.write_cmd.req_cmd_pld.addr        = 16'(tag * 256 + seq);
    p.write_cmd.wr_id                   = 8'(tag);
    p.data                              = {8'hA5, 8'(tag), 16'(seq)};
    return p;
  endfunction

  task automatic push_exp(input int l, input write_ram_pld_t p);
    exp_t e;
    e.pld = p;
    e.sel = int'(p.write_cmd.req_cmd_pld.dest_ram_id) % R;
    exp_q[l].push_back(e);
    acc_cnt[l]++;
  endtask

  // Acceptor: every handshake seen on the inputs becomes an expected output for that lane.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int l = 0; l < LANES; l++)
        if (cmd_vld[l] && cmd_rdy[l]) push_exp(l, cmd_pld[l]);
      for (int h = 0; h < HASH_NUM; h++)
        if (lf_vld[h] && lf_rdy[h]) push_exp(SOUTH * HASH_NUM + h, lf_pld[h]);
    end
  end

  // Monitor: whatever a lane presents must be the head of its queue on the right output.
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("sel_err_idle", 64'(sel_err), 64'd0);
      for (int l = 0; l < LANES; l++) begin
        int nv;
        int kh;
        nv = 0;
        kh = 0;
        for (int k = 0; k < R; k++) begin
          if (ram_vld[l*R+k]) begin
            nv++;
            kh = k;
          end
        end
        if (nv > 1) begin
          check_eq("lane_onehot", 64'(nv), 64'd1);
        end else if (nv == 1) begin
          if (exp_q[l].size() == 0) begin
            check_eq("unexpected_out", 64'(exp_q[l].size()), 64'd1);
          end else begin
            check_eq("route_sel", 64'(kh), 64'(exp_q[l][0].sel));
            for (int k = 0; k < R; k++)
              check_eq("out_pld", 64'(ram_pld[l*R+k]), 64'(exp_q[l][0].pld));
            if (ram_rdy[l*R+kh]) begin
              void'(exp_q[l].pop_front());
              fire_cnt[l]++;
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic wait_drain(input string nm);
    int  t;
    bit  empty;
    t = 0;
    empty = 1'b0;
    while (!empty && t < 60) begin
      @(posedge clk);
      empty = (ram_vld == '0);
      for (int l = 0; l < LANES; l++)
        if (exp_q[l].size() != 0) empty = 1'b0;
      t++;
    end
    #1;
    check_eq(nm, 64'(empty), 64'd1);
  endtask

  task automatic send(input int l, input write_ram_pld_t p);
    int t;
    t = 0;
    cmd_pld[l] = p;
    cmd_vld[l] = 1'b1;
    @(negedge clk);
    while (!cmd_rdy[l] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("send_accept", 64'(cmd_rdy[l]), 64'd1);
    @(posedge clk);
    #1;
    cmd_vld[l] = 1'b0;
  endtask

  // Both requesters held high; the bench's own counter predicts who gets the slot.
  task automatic starve_run(input int h, input int n);
    int l;
    int cnt;
    bit exp_lf;
    l = SOUTH * HASH_NUM + h;
    cnt = 0;
    cmd_pld[l] = mk(l, 500, 0);
    lf_pld[h]  = mk(16 + h, 500, 1);
    cmd_vld[l] = 1'b1;
    lf_vld[h]  = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp_lf = (cnt < STARVE);
      check_eq("arb_lf_rdy", 64'(lf_rdy[h]), 64'(exp_lf));
      check_eq("arb_cmd_rdy", 64'(cmd_rdy[l]), 64'(!exp_lf));
      cnt = exp_lf ? cnt + 1 : 0;
      @(posedge clk);
      #1;
      if (exp_lf) lf_pld[h] = mk(16 + h, 501 + i, i);
      else        cmd_pld[l] = mk(l, 501 + i, i + 1);
    end
  endtask

  write_ram_pld_t      p;
  int                  sq [LANES];
  int                  lsq [HASH_NUM];
  logic [LANES-1:0]    al;
  logic [HASH_NUM-1:0] af;

  initial begin
    rst_n     = 1'b0;
    cmd_vld   = '0;
    lf_vld    = '0;
    ram_rdy   = '1;
    b_cmd_vld = '0;
    b_lf_vld  = '0;
    b_ram_rdy = '1;
    for (int l = 0; l < LANES; l++) begin
      cmd_pld[l]   = '0;
      b_cmd_pld[l] = '0;
    end
    for (int h = 0; h < HASH_NUM; h++) begin
      lf_pld[h]   = '0;
      b_lf_pld[h] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ram_vld", 64'(ram_vld), 64'd0);
    check_eq("rst_ram_pld", 64'(ram_pld[5]), 64'd0);
    check_eq("rst_cmd_rdy", 64'(cmd_rdy), 64'hFFFF);
    check_eq("rst_sel_err", 64'(sel_err), 64'd0);
    check_eq("rst_b_cmd_rdy", 64'(b_cmd_rdy), 64'hFFFF);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Routing: W lane h=1, dest 1 -> output 3 only, one cycle later
    p = mk(1, 0, 1);
    cmd_pld[1] = p;
    cmd_vld[1] = 1'b1;
    @(posedge clk);
    #1;
    cmd_vld[1] = 1'b0;
    check_eq("route_vld", 64'(ram_vld), 64'h8);
    check_eq("route_pld2", 64'(ram_pld[2]), 64'(p));
    check_eq("route_pld3", 64'(ram_pld[3]), 64'(p));
    wait_drain("drain_route");

    // Backpressure: E lane h=0, sel 0,1,0 with output 8 stalled for two cycles
    acc_cnt[4]  = 0;
    fire_cnt[4] = 0;
    ram_rdy[8]  = 1'b0;
    fork
      begin
        send(4, mk(4, 0, 0));
        send(4, mk(4, 1, 1));
        send(4, mk(4, 2, 0));
      end
      begin
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_rdy_low0", 64'(cmd_rdy[4]), 64'd0);
        @(negedge clk);
        check_eq("bp_rdy_low1", 64'(cmd_rdy[4]), 64'd0);
        @(posedge clk);
        #1;
        ram_rdy[8] = 1'b1;
      end
    join
    wait_drain("drain_bp");
    check_eq("bp_in_cnt", 64'(acc_cnt[4]), 64'd3);
    check_eq("bp_out_cnt", 64'(fire_cnt[4]), 64'd3);

    // Collision and starvation on south hash 2
    starve_run(2, 15);
    cmd_vld = '0;
    lf_vld  = '0;
    wait_drain("drain_starve");

    // Throughput: every lane and every linefill valid for 100 cycles
    for (int l = 0; l < LANES; l++) begin
      acc_cnt[l]  = 0;
      fire_cnt[l] = 0;
      sq[l]       = 0;
      cmd_pld[l]  = mk(l, 0, l);
    end
    for (int h = 0; h < HASH_NUM; h++) begin
      lsq[h]    = 0;
      lf_pld[h] = mk(16 + h, 0, h + 1);
    end
    cmd_vld = '1;
    lf_vld  = '1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      al = cmd_vld & cmd_rdy;
      af = lf_vld & lf_rdy;
      @(posedge clk);
      #1;
      for (int l = 0; l < LANES; l++)
        if (al[l]) begin
          sq[l]++;
          cmd_pld[l] = mk(l, sq[l], sq[l] + l);
        end
      for (int h = 0; h < HASH_NUM; h++)
        if (af[h]) begin
          lsq[h]++;
          lf_pld[h] = mk(16 + h, lsq[h], lsq[h] + h + 1);
        end
    end
    cmd_vld = '0;
    lf_vld  = '0;
    wait_drain("drain_tput");
    for (int l = 0; l < LANES; l++) begin
      check_eq("tput_in", 64'(acc_cnt[l]), 64'd100);
      check_eq("tput_out", 64'(fire_cnt[l]), 64'd100);
    end

    // Reset mid-stream while south hash 1 is partly starved
    starve_run(1, 3);
    check_eq("pre_rst_busy", 64'(|ram_vld), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_clr", 64'(ram_vld), 64'd0);
    cmd_vld = '0;
    lf_vld  = '0;
    for (int l = 0; l < LANES; l++) exp_q[l].delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst2_cmd_rdy", 64'(cmd_rdy), 64'hFFFF);
    check_eq("rst2_ram_vld", 64'(ram_vld), 64'd0);
    starve_run(1, 10);
    cmd_vld = '0;
    lf_vld  = '0;
    wait_drain("drain_rst");

    // Out-of-range select on the 3-RAM instance
    p = mk(0, 7, 3);
    b_cmd_pld[0] = p;
    b_cmd_vld[0] = 1'b1;
    @(negedge clk);
    check_eq("selerr_rdy", 64'(b_cmd_rdy[0]), 64'd1);
    @(posedge clk);
    #1;
    b_cmd_vld[0] = 1'b0;
    check_eq("selerr_no_vld", 64'(b_ram_vld), 64'd0);
    check_eq("selerr_pulse", 64'(b_sel_err), 64'h1);
    @(posedge clk);
    #1;
    check_eq("selerr_one_cycle", 64'(b_sel_err), 64'd0);
    check_eq("selerr_still_empty", 64'(b_ram_vld), 64'd0);
    p = mk(0, 8, 2);
    b_cmd_pld[0] = p;
    b_cmd_vld[0] = 1'b1;
    @(posedge clk);
    #1;
    b_cmd_vld[0] = 1'b0;
    check_eq("sel2_vld", 64'(b_ram_vld), 64'h4);
    check_eq("sel2_pld", 64'(b_ram_pld[2]), 64'(p));
    check_eq("sel2_no_err", 64'(b_sel_err), 64'd0);

    repeat (3) @(posedge clk);
    for (int l = 0; l < LANES; l++)
      check_eq("final_q_empty", 64'(exp_q[l].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
